// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour field widths and sync-stage types.
// Latency: n/a (definitions only).
// Backpressure: n/a; the pixel generator imports this to agree on field widths.
package vga_pkg;

  // 640x480 @ 60 Hz defaults, in pixels / lines
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;  // 800
  localparam int V_TOTAL = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;  // 525

  // Sync pulse windows, [start, end)
  localparam int H_SYNC_START = H_ACTIVE_D + H_FP_D;      // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_D;  // 752
  localparam int V_SYNC_START = V_ACTIVE_D + V_FP_D;      // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_D;  // 492

  // Counter and colour widths
  localparam int CNT_W   = 10;
  localparam int PIX_X_W = 10;
  localparam int PIX_Y_W = 9;
  localparam int COLOR_W = 4;
  localparam int RGB_W   = 3 * COLOR_W;

  // Per-pixel control carried alongside the pixel pipeline
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_t;

  // Blanking with both syncs released (active-low)
  localparam sync_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // True when cnt lies in [lo, hi)
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that lines control bits up with a pipelined pixel source.
// Latency: DEPTH enabled cycles; DEPTH=0 is a plain wire.
// Backpressure: none; stages only advance when en_i is high, otherwise they hold.
module vga_delay_line #(
  parameter int               DEPTH   = 0,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  if (DEPTH == 0) begin : g_wire
    // No storage: clock, reset and enable are intentionally unused here
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en_i};
    assign dout_o = din_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per enable; reset fills every stage with the idle value
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (en_i) begin
        stage_q[0] <= din_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel divider, h/v counters, sync generation, registered colour out.
// Latency: sync/colour outputs trail coordinate issue by PIPE_LAT+1 pixel periods.
// Backpressure: none; free-running raster, rgb_in must be valid by the capturing pix_tick.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int PIPE_LAT = 0,  // 0 only legal with CLK_DIV >= 2 (1-clk ROM latency)
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [PIX_X_W-1:0] pix_x,
  output logic [PIX_Y_W-1:0] pix_y,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               frame_tick
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic               tick;
  sync_t              s0, s_dly;
  logic               hsync_q, vsync_q, frame_q, frame_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // Last clock of each pixel period; held low while reset is asserted
  always_comb begin
    tick     = (div_q == DIV_LAST);
    pix_tick = tick & ~rst;
  end

  // Next-state for the divider and the raster counters
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  // Divider and raster counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Stage-0 decode of the current raster position and the coordinates handed out
  always_comb begin
    s0.active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    s0.hsync  = ~in_window(h_q, HS_START, HS_END);
    s0.vsync  = ~in_window(v_q, VS_START, VS_END);
    pix_x     = s0.active ? h_q : '0;
    pix_y     = s0.active ? v_q[PIX_Y_W-1:0] : '0;
  end

  // Hold sync/active back by the pixel generator's pipeline depth
  vga_delay_line #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   ($bits(sync_t)),
    .RST_VAL (SYNC_IDLE)
  ) u_dly (
    .clk    (clk),
    .rst    (rst),
    .en_i   (tick),
    .din_i  (s0),
    .dout_o (s_dly)
  );

  // End of the last active line, one pulse per frame
  always_comb begin
    frame_d = tick && (h_q == H_LAST) && (v_q == V_ACT_LAST);
  end

  // Output registers: update once per pixel so pins are stable for the whole period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      frame_q <= 1'b0;
    end else begin
      if (tick) begin
        hsync_q <= s_dly.hsync;
        vsync_q <= s_dly.vsync;
        r_q     <= s_dly.active ? rgb_in[3*COLOR_W-1:2*COLOR_W] : '0;
        g_q     <= s_dly.active ? rgb_in[2*COLOR_W-1:COLOR_W]   : '0;
        b_q     <= s_dly.active ? rgb_in[COLOR_W-1:0]           : '0;
      end
      frame_q <= frame_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = b_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Two instances on a shrunken raster (15x8 total, 8x4 active):
//   d0: CLK_DIV=4, PIPE_LAT=0, constant rgb_in
//   d1: CLK_DIV=1, PIPE_LAT=1, rgb_in from a 1-clk ROM of {3{pix_x[3:0]}}
// Outputs are sampled on the falling edge against an independent raster model.
module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 2, HT = HA + HF + HSW + HB;  // 15
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1, VT = VA + VF + VSW + VB;  // 8
  localparam int FR = HT * VT;                                               // 120
  localparam int HS0 = HA + HF, HS1 = HS0 + HSW;                             // [10,13)
  localparam int VS0 = VA + VF, VS1 = VS0 + VSW;                             // [5,7)

  int CD [2] = '{4, 1};
  int PL [2] = '{0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [11:0]      rgb0, rgb1;
  logic [1:0][9:0]  px;
  logic [1:0][8:0]  py;
  logic [1:0]       ptk, hs, vs, ft;
  logic [1:0][3:0]  vr, vg, vb;

  vga_timing_ctrl #(
    .CLK_DIV(4), .PIPE_LAT(0),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut0 (
    .clk(clk), .rst(rst), .rgb_in(rgb0),
    .pix_x(px[0]), .pix_y(py[0]), .pix_tick(ptk[0]),
    .hsync(hs[0]), .vsync(vs[0]),
    .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]),
    .frame_tick(ft[0])
  );

  vga_timing_ctrl #(
    .CLK_DIV(1), .PIPE_LAT(1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut1 (
    .clk(clk), .rst(rst), .rgb_in(rgb1),
    .pix_x(px[1]), .pix_y(py[1]), .pix_tick(ptk[1]),
    .hsync(hs[1]), .vsync(vs[1]),
    .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]),
    .frame_tick(ft[1])
  );

  // Pixel generator for d1: colour-by-column ROM with one clock of latency
  always @(posedge clk) rgb1 <= {3{px[1][3:0]}};

  int checks = 0;
  int failures = 0;
  int m_div [2], m_h [2], m_v [2], m_n [2];
  bit m_ft [2];
  int hs_cnt [2], vs_cnt [2], ft_cnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_div[d] = 0; m_h[d] = 0; m_v[d] = 0; m_n[d] = 0; m_ft[d] = 1'b0;
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      hs_cnt[d] = 0; vs_cnt[d] = 0; ft_cnt[d] = 0;
    end
  endtask

  // Advance the reference raster by one rising edge
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      m_ft[d] = (m_div[d] == CD[d] - 1) && (m_h[d] == HT - 1) && (m_v[d] == VA - 1);
      if (m_div[d] == CD[d] - 1) begin
        m_div[d] = 0;
        m_n[d]++;
        if (m_h[d] == HT - 1) begin
          m_h[d] = 0;
          m_v[d] = (m_v[d] == VT - 1) ? 0 : m_v[d] + 1;
        end else begin
          m_h[d] = m_h[d] + 1;
        end
      end else begin
        m_div[d] = m_div[d] + 1;
      end
    end
  endtask

  // Compare every output of both instances against the model
  task automatic check_all();
    int q, dh, dv;
    logic e_act, e_dact, e_hs, e_vs, e_tick;
    logic [9:0] e_px;
    logic [8:0] e_py;
    logic [11:0] e_col;
    for (int d = 0; d < 2; d++) begin
      e_tick = !rst && (m_div[d] == CD[d] - 1);
      e_act  = (m_h[d] < HA) && (m_v[d] < VA);
      e_px   = e_act ? 10'(m_h[d]) : 10'd0;
      e_py   = e_act ? 9'(m_v[d]) : 9'd0;
      e_hs = 1'b1; e_vs = 1'b1; e_col = 12'h000;
      if (!rst && m_n[d] >= 1 + PL[d]) begin
        // Outputs show the pixel issued PIPE_LAT+1 periods earlier
        q  = (m_v[d] * HT + m_h[d] - 1 - PL[d] + FR) % FR;
        dh = q % HT;
        dv = q / HT;
        e_dact = (dh < HA) && (dv < VA);
        e_hs   = !((dh >= HS0) && (dh < HS1));
        e_vs   = !((dv >= VS0) && (dv < VS1));
        if (e_dact) e_col = (d == 0) ? rgb0 : {3{4'(dh)}};
      end
      chk($sformatf("d%0d_pix_tick", d), 32'(ptk[d]), 32'(e_tick));
      chk($sformatf("d%0d_pix_x", d), 32'(px[d]), 32'(e_px));
      chk($sformatf("d%0d_pix_y", d), 32'(py[d]), 32'(e_py));
      chk($sformatf("d%0d_hsync", d), 32'(hs[d]), 32'(e_hs));
      chk($sformatf("d%0d_vsync", d), 32'(vs[d]), 32'(e_vs));
      chk($sformatf("d%0d_rgb", d), 32'({vr[d], vg[d], vb[d]}), 32'(e_col));
      chk($sformatf("d%0d_frame_tick", d), 32'(ft[d]), 32'(!rst && m_ft[d]));
      if (hs[d] === 1'b0) hs_cnt[d]++;
      if (vs[d] === 1'b0) vs_cnt[d]++;
      if (ft[d] === 1'b1) ft_cnt[d]++;
    end
  endtask

  task automatic run_check(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  // Hand-computed sample counts over 960 clocks after reset release
  task automatic check_window_counts(input string tag);
    chk({tag, "_d0_hsync_low_clks"}, 32'(hs_cnt[0]), 32'd192);  // 16 lines x 3 px x 4 clk
    chk({tag, "_d0_vsync_low_clks"}, 32'(vs_cnt[0]), 32'd240);  // 2 frames x 30 px x 4 clk
    chk({tag, "_d0_frame_ticks"},    32'(ft_cnt[0]), 32'd2);
    chk({tag, "_d1_hsync_low_clks"}, 32'(hs_cnt[1]), 32'd192);  // 64 lines x 3 px
    chk({tag, "_d1_vsync_low_clks"}, 32'(vs_cnt[1]), 32'd240);  // 8 frames x 30 px
    chk({tag, "_d1_frame_ticks"},    32'(ft_cnt[1]), 32'd8);
  endtask

  initial begin
    rst  = 1'b1;
    rgb0 = 12'hFFF;
    model_reset();
    clear_counts();

    // Reset values before any clock edge, then while clocking in reset
    #2;
    check_all();
    run_check(3);

    // Release; d0 must not tick before its 4th edge
    rst = 1'b0;
    clear_counts();
    run_check(2);
    chk("d0_tick_before_edge3", 32'(ptk[0]), 32'd0);
    run_check(1);
    chk("d0_tick_after_edge3", 32'(ptk[0]), 32'd1);
    chk("d0_rgb_before_capture", 32'({vr[0], vg[0], vb[0]}), 32'h000);
    run_check(957);
    check_window_counts("w1");

    // Into active video of the next frame, then reset asynchronously mid-period
    run_check(80);
    chk("d0_rgb_pre_reset", 32'({vr[0], vg[0], vb[0]}), 32'hFFF);
    #2;
    rst  = 1'b1;
    rgb0 = 12'h5A3;
    model_reset();
    #1;
    chk("d0_rgb_async_reset", 32'({vr[0], vg[0], vb[0]}), 32'h000);
    chk("d0_pix_x_async_reset", 32'(px[0]), 32'd0);
    check_all();
    run_check(2);

    // Scanning restarts from (0,0) with a new colour; full frames incl. wrap
    rst = 1'b0;
    clear_counts();
    run_check(960);
    check_window_counts("w2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
